// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake: a main entry that drives
// the outputs, plus an optional skid entry that lets inReady come from a flop.
module pipe_stage_reg #(
  parameter int unsigned DATA_W      = 134,
  parameter int unsigned SKID        = 1,
  parameter int unsigned BUBBLE_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inData,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outData,
  output logic [1:0]        occupancy
);

  logic              main_vld_p1;
  logic [DATA_W-1:0] main_data_p1;
  logic              skid_vld_p1;

  logic              accept;
  logic              issue;
  logic              main_free;

  logic              main_vld_d;
  logic              main_load;
  logic [DATA_W-1:0] main_data_d;

  function automatic logic [DATA_W-1:0] bubble_mask(
    input logic              vld,
    input logic [DATA_W-1:0] data
  );
    if ((BUBBLE_ZERO != 0) && !vld) begin
      return '0;
    end
    return data;
  endfunction

  assign accept    = inValid & inReady;
  assign issue     = main_vld_p1 & outReady;
  assign main_free = ~main_vld_p1 | issue;

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_vld_d;
      logic              skid_load;
      logic              ready_q;
      logic [DATA_W-1:0] skid_data_p1;

      always_comb begin
        main_vld_d  = main_vld_p1;
        main_load   = 1'b0;
        main_data_d = skid_data_p1;
        skid_vld_d  = skid_vld_p1;
        skid_load   = 1'b0;
        if (flush) begin
          main_vld_d = 1'b0;
          skid_vld_d = 1'b0;
        end else if (main_free) begin
          // The older skid entry always wins the main slot to keep arrival order.
          if (skid_vld_p1) begin
            main_load   = 1'b1;
            main_vld_d  = 1'b1;
            main_data_d = skid_data_p1;
            skid_vld_d  = accept;
            skid_load   = accept;
          end else if (accept) begin
            main_load   = 1'b1;
            main_vld_d  = 1'b1;
            main_data_d = inData;
          end else begin
            main_vld_d = 1'b0;
          end
        end else if (accept) begin
          skid_load  = 1'b1;
          skid_vld_d = 1'b1;
        end
      end

      // Skid entry and its registered ready
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          skid_vld_p1  <= 1'b0;
          skid_data_p1 <= '0;
          ready_q      <= 1'b1;
        end else begin
          skid_vld_p1 <= skid_vld_d;
          ready_q     <= ~skid_vld_d;
          if (skid_load) begin
            skid_data_p1 <= inData;
          end
        end
      end

      assign inReady = ready_q;

`ifndef SYNTHESIS
      a_skid_behind_main: assert property (@(posedge clk) disable iff (!rst_n)
        skid_vld_p1 |-> main_vld_p1);
      a_ready_tracks_skid: assert property (@(posedge clk) disable iff (!rst_n)
        inReady == !skid_vld_p1);
`endif
    end else begin : g_single
      always_comb begin
        main_vld_d  = main_vld_p1;
        main_load   = 1'b0;
        main_data_d = inData;
        if (flush) begin
          main_vld_d = 1'b0;
        end else if (main_free) begin
          main_vld_d = accept;
          main_load  = accept;
        end
      end

      assign skid_vld_p1 = 1'b0;
      assign inReady     = main_free;
    end
  endgenerate

  // Main entry, drives the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_p1  <= 1'b0;
      main_data_p1 <= '0;
    end else begin
      main_vld_p1 <= main_vld_d;
      if (main_load) begin
        main_data_p1 <= main_data_d;
      end
    end
  end

  assign outValid  = main_vld_p1;
  assign outData   = bubble_mask(main_vld_p1, main_data_p1);
  assign occupancy = {1'b0, main_vld_p1} + {1'b0, skid_vld_p1};

`ifndef SYNTHESIS
  a_occupancy_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= ((SKID != 0) ? 2'd2 : 2'd1));
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a single-entry instance, each
// compared every cycle against a queue model of the handshake rules.
module tb_pipe_stage_reg;
  localparam int W = 134;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [W-1:0] in_data_a, out_data_a;
  logic [1:0]   occ_a;
  logic         flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [W-1:0] in_data_b, out_data_b;
  logic [1:0]   occ_b;

  pipe_stage_reg #(.DATA_W(W), .SKID(1), .BUBBLE_ZERO(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a),
    .inValid(in_valid_a), .inReady(in_ready_a), .inData(in_data_a),
    .outValid(out_valid_a), .outReady(out_ready_a), .outData(out_data_a),
    .occupancy(occ_a)
  );

  pipe_stage_reg #(.DATA_W(W), .SKID(0), .BUBBLE_ZERO(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b),
    .inValid(in_valid_b), .inReady(in_ready_b), .inData(in_data_b),
    .outValid(out_valid_b), .outReady(out_ready_b), .outData(out_data_b),
    .occupancy(occ_b)
  );

  int tests = 0;
  int fails = 0;
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_data();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Queue model: capacity 2 with ready = not full (skid), or capacity 1 with
  // ready = empty or draining (single entry); flush empties everything.
  task automatic model_edge();
    bit acc, iss;
    iss = (qa.size() > 0) && out_ready_a;
    acc = in_valid_a && (qa.size() < 2);
    if (flush_a) qa.delete();
    else begin
      if (iss) void'(qa.pop_front());
      if (acc) qa.push_back(in_data_a);
    end
    iss = (qb.size() > 0) && out_ready_b;
    acc = in_valid_b && ((qb.size() == 0) || out_ready_b);
    if (flush_b) qb.delete();
    else begin
      if (iss) void'(qb.pop_front());
      if (acc) qb.push_back(in_data_b);
    end
  endtask

  task automatic check_outputs();
    check("a_valid", W'(out_valid_a), W'(qa.size() > 0));
    check("a_data",  out_data_a, (qa.size() > 0) ? qa[0] : '0);
    check("a_occ",   W'(occ_a), W'(qa.size()));
    check("a_ready", W'(in_ready_a), W'(qa.size() < 2));
    check("b_valid", W'(out_valid_b), W'(qb.size() > 0));
    check("b_data",  out_data_b, (qb.size() > 0) ? qb[0] : '0);
    check("b_occ",   W'(occ_b), W'(qb.size()));
    check("b_ready", W'(in_ready_b), W'((qb.size() == 0) || out_ready_b));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    flush_a = 0; in_valid_a = 0; out_ready_a = 0; in_data_a = '0;
    flush_b = 0; in_valid_b = 0; out_ready_b = 0; in_data_b = '0;

    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", W'(out_valid_a), W'(0));
    check("rst_data",  out_data_a, '0);
    check("rst_occ",   W'(occ_a), W'(0));
    check("rst_ready", W'(in_ready_a), W'(1));
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Stream: one entry in flight, data emerges one edge after accept
    out_ready_a = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid_a = 1; in_data_a = W'(i);
      step();
      check("stream_data",  out_data_a, W'(i));
      check("stream_occ",   W'(occ_a), W'(1));
      check("stream_ready", W'(in_ready_a), W'(1));
    end
    in_valid_a = 0;
    step();

    // Backpressure: two entries held, third offered but refused
    out_ready_a = 0; in_valid_a = 1; in_data_a = W'(32'hA);
    step();
    in_data_a = W'(32'hB);
    step();
    check("bp_occ",   W'(occ_a), W'(2));
    check("bp_ready", W'(in_ready_a), W'(0));
    in_data_a = W'(32'hC);
    step();
    check("bp_hold", out_data_a, W'(32'hA));
    out_ready_a = 1;
    step();
    check("bp_second", out_data_a, W'(32'hB));
    step();
    check("bp_third", out_data_a, W'(32'hC));
    in_valid_a = 0;
    step();
    check("bp_drained", W'(occ_a), W'(0));

    // Flush with a full stage and a live offer
    out_ready_a = 0; in_valid_a = 1; in_data_a = W'(32'h71);
    step();
    in_data_a = W'(32'h72);
    step();
    in_data_a = W'(32'h73); flush_a = 1;
    step();
    check("flush_valid", W'(out_valid_a), W'(0));
    check("flush_data",  out_data_a, '0);
    check("flush_occ",   W'(occ_a), W'(0));
    check("flush_ready", W'(in_ready_a), W'(1));
    flush_a = 0; in_valid_a = 0;
    step();
    check("flush_discard", W'(occ_a), W'(0));

    // Single-entry stage: issue and reload on the same edge
    out_ready_b = 0; in_valid_b = 1; in_data_b = W'(32'h5);
    step();
    in_data_b = W'(32'h6);
    #1 check("s0_ready_low", W'(in_ready_b), W'(0));
    out_ready_b = 1;
    #1 check("s0_ready_high", W'(in_ready_b), W'(1));
    step();
    check("s0_next", out_data_b, W'(32'h6));
    check("s0_occ",  W'(occ_b), W'(1));
    in_valid_b = 0;
    step();

    // Asynchronous reset between edges with a full stage
    out_ready_a = 0; in_valid_a = 1; in_data_a = W'(32'h11);
    step();
    in_data_a = W'(32'h22);
    step();
    in_valid_a = 0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", W'(out_valid_a), W'(0));
    check("arst_data",  out_data_a, '0);
    check("arst_occ",   W'(occ_a), W'(0));
    check("arst_ready", W'(in_ready_a), W'(1));
    qa.delete(); qb.delete();
    check_outputs();
    #1 rst_n = 1'b1;
    out_ready_a = 1;
    step();
    check("arst_after", W'(out_valid_a), W'(0));
    in_valid_a = 1; in_data_a = W'(32'h33);
    step();
    check("arst_fresh", out_data_a, W'(32'h33));
    in_valid_a = 0;
    step();

    // Random traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      in_valid_a  = ($urandom_range(99) < 60);
      out_ready_a = ($urandom_range(99) < 55);
      flush_a     = ($urandom_range(99) < 2);
      in_data_a   = rnd_data();
      in_valid_b  = ($urandom_range(99) < 60);
      out_ready_b = ($urandom_range(99) < 55);
      flush_b     = ($urandom_range(99) < 2);
      in_data_b   = rnd_data();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 134, width of the payload bundle (PC, instruction, ALU result, store data, destination register, control bits).
REQ-002 The block SHALL have parameter SKID, default 1, where 1 selects a two-entry skid stage with registered inReady and 0 selects a single-entry stage.
REQ-003 The block SHALL have parameter BUBBLE_ZERO, default 1, where 1 forces outData to all-zero (NOP bundle) whenever outValid is 0.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port flush, input, 1 bit, synchronous kill of all held entries.
REQ-007 The block SHALL have port inValid, input, 1 bit, upstream offers inData.
REQ-008 The block SHALL have port inReady, output, 1 bit, stage can accept inData this cycle.
REQ-009 The block SHALL have port inData, input, DATA_W bits, upstream payload.
REQ-010 The block SHALL have port outValid, output, 1 bit, outData holds a live entry.
REQ-011 The block SHALL have port outReady, input, 1 bit, downstream consumes outData this cycle.
REQ-012 The block SHALL have port outData, output, DATA_W bits, payload of the oldest entry.
REQ-013 The block SHALL have port occupancy, output, 2 bits, count of live entries (0..2).

Function
REQ-014 Accept SHALL occur on a rising edge with inValid=1 and inReady=1; issue SHALL occur on a rising edge with outValid=1 and outReady=1.
REQ-015 Storage SHALL be a main register (drives outData/outValid) plus, when SKID=1, a skid register with its own valid bit.
REQ-016 With SKID=1, inReady SHALL equal NOT skidValid, driven directly from a flop with no combinational path from outReady.
REQ-017 With SKID=0, inReady SHALL be (NOT mainValid) OR outReady, and the skid register SHALL not exist.
REQ-018 When main is empty or issuing, main SHALL load the skid entry if skidValid, else the accepted input, else become empty.
REQ-019 When main is full and not issuing, an accepted input SHALL be written to the skid register.
REQ-020 When the skid entry moves to main in the same edge as an accept, the input SHALL go to skid; entries SHALL leave in strict arrival order.
REQ-021 Empty stage with accept SHALL yield outValid=1 and outData=that input after exactly one edge (latency 1).
REQ-022 No entry SHALL be duplicated or dropped except by flush or reset.
REQ-023 flush=1 at an edge SHALL clear mainValid and skidValid; any input or issue on that edge SHALL be discarded; flush SHALL override all other events.
REQ-024 Payload registers SHALL load only on the edges described above and SHALL otherwise hold.
REQ-025 occupancy SHALL equal mainValid+skidValid and SHALL never exceed 1 when SKID=0.
REQ-026 outData SHALL be zero while outValid=0 if BUBBLE_ZERO=1; otherwise it SHALL show the stale main payload.

Reset
REQ-027 rst_n low SHALL immediately clear mainValid, skidValid and all payload registers, giving outValid=0, outData=0, occupancy=0 and inReady=1.
REQ-028 Reset asserted mid-transfer SHALL discard all entries; the first rising edge after deassertion SHALL behave as from the empty state.

Verification
REQ-029 Stream test (SKID=1): inValid=1 with data 1,2,3,4 on consecutive edges, outReady=1 -> outData 1,2,3,4 one edge later each, occupancy steady at 1, inReady constantly 1.
REQ-030 Backpressure test (SKID=1): accept 0xA then 0xB with outReady=0 -> occupancy=2, inReady=0, 0xC held off; raise outReady -> 0xA, 0xB, 0xC issued in order.
REQ-031 Flush test: occupancy=2 and inValid=1 with flush=1 for one edge -> next cycle outValid=0, outData=0, occupancy=0, inReady=1, the input discarded.
REQ-032 SKID=0 test: main holds 0x5 with outReady=0 -> inReady=0; set outReady=1 and inValid=1 with 0x6 -> 0x5 issued and 0x6 loaded on the same edge.
REQ-033 Async reset test: rst_n pulsed low between edges with occupancy=2 -> outputs cleared before the next edge; no data from before reset ever appears.
REQ-034 Random test: random inValid/outReady/flush (flush 2%) vs. a queue model -> order and data match, occupancy<=2, never issue while outValid=0.
